// File: rtl/apb_sample_store.sv
// APB completer holding a sample RAM, a saturating write counter and a control register.
// Programmable wait states; illegal accesses answer with pslverr_o.
module apb_sample_store #(
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [7:0]  THRESH_RST  = 8'd100
) (
    input  logic        pclk_i,
    input  logic        preset_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [7:0]  paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic [15:0] count_o,
    output logic        irq_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WaitInit = 4'(WAIT_STATES);
    localparam logic [7:0] AddrCount = 8'hF8;
    localparam logic [7:0] AddrCtrl  = 8'hFC;

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [15:0] count_q, count_d;
    logic [7:0]  thresh_q, thresh_d;
    logic        irq_q;

    logic [31:0] ram [DEPTH];

    logic          setup;
    logic          is_ram, is_count, is_ctrl, err, wr_ok, ram_we;
    logic [AW-1:0] ram_idx;
    logic [31:0]   rd_word;

    assign setup   = (state_q == StIdle) && psel_i && !penable_i;
    assign ram_idx = addr_q[AW-1:0];

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: begin
                if (psel_i && !penable_i) begin
                    state_d = StAccess;
                    wait_d  = WaitInit;
                end
            end
            StAccess: begin
                if (!psel_i) begin
                    state_d = StIdle;
                end else if (penable_i) begin
                    if (wait_q != 4'd0) begin
                        wait_d = wait_q - 4'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pready_o = (state_q == StAccess) && psel_i && penable_i && (wait_q == 4'd0);

    // Decode uses the address/direction captured at setup, not the live bus.
    always_comb begin
        is_ram   = 32'(addr_q) < DEPTH;
        is_count = addr_q == AddrCount;
        is_ctrl  = addr_q == AddrCtrl;
        err      = !(is_ram || is_ctrl || (is_count && !write_q));
        wr_ok    = pready_o && write_q && !err;
        ram_we   = wr_ok && is_ram && !preset_i;
    end

    always_comb begin
        rd_word = 32'h0;
        if (is_ram) begin
            rd_word = ram[ram_idx];
        end else if (is_count) begin
            rd_word = {16'h0, count_q};
        end else if (is_ctrl) begin
            rd_word = {24'h0, thresh_q};
        end
    end

    always_comb begin
        pslverr_o = pready_o && err;
        prdata_o  = 32'h0;
        if (pready_o && !write_q && !err) begin
            prdata_o = rd_word;
        end
    end

    always_comb begin
        count_d  = count_q;
        thresh_d = thresh_q;
        if (wr_ok && is_ram && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
        if (wr_ok && is_ctrl) begin
            thresh_d = wdata_q[7:0];
            if (wdata_q[8]) begin
                count_d = 16'h0;
            end
        end
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q  <= StIdle;
            wait_q   <= 4'd0;
            addr_q   <= 8'h0;
            write_q  <= 1'b0;
            wdata_q  <= 32'h0;
            count_q  <= 16'h0;
            thresh_q <= THRESH_RST;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            count_q  <= count_d;
            thresh_q <= thresh_d;
            irq_q    <= (thresh_d != 8'h0) && (count_d >= {8'h0, thresh_d});
            if (setup) begin
                addr_q  <= paddr_i;
                write_q <= pwrite_i;
                wdata_q <= pwdata_i;
            end
        end
    end

    // Sample storage is deliberately not reset.
    always_ff @(posedge pclk_i) begin
        if (ram_we) begin
            ram[ram_idx] <= wdata_q;
        end
    end

    assign count_o = count_q;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_apb_sample_store.sv
// Directed bench: one instance with one wait state, one with zero wait states,
// each on its own psel line over a shared bus.
module tb_apb_sample_store;

    logic        clk = 1'b0;
    logic        preset;
    logic        psel1, psel0, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata1, prdata0;
    logic        pready1, pready0, pslverr1, pslverr0, irq1, irq0;
    logic [15:0] count1, count0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    apb_sample_store #(.DEPTH(128), .WAIT_STATES(1), .THRESH_RST(8'd100)) u_ws1 (
        .pclk_i(clk), .preset_i(preset), .psel_i(psel1), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata1),
        .pready_o(pready1), .pslverr_o(pslverr1), .count_o(count1), .irq_o(irq1)
    );

    apb_sample_store #(.DEPTH(128), .WAIT_STATES(0), .THRESH_RST(8'd100)) u_ws0 (
        .pclk_i(clk), .preset_i(preset), .psel_i(psel0), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata0),
        .pready_o(pready0), .pslverr_o(pslverr0), .count_o(count0), .irq_o(irq0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Full transfer on instance `sel` (1 = wait-state unit, 0 = zero-wait unit).
    // Returns with the completing edge already passed, #1 after it.
    task automatic apb(input bit sel, input logic [7:0] addr, input bit wr,
                       input logic [31:0] data, output logic [31:0] rdata,
                       output logic err, output int waits);
        bit done = 0;
        rdata = 32'h0;
        err   = 1'b0;
        waits = 0;
        @(posedge clk); #1;
        psel1 = sel; psel0 = !sel; penable = 1'b0;
        paddr = addr; pwrite = wr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (sel ? pready1 : pready0) begin
                rdata = sel ? prdata1 : prdata0;
                err   = sel ? pslverr1 : pslverr0;
                done  = 1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        psel1 = 1'b0; psel0 = 1'b0; penable = 1'b0;
        if (!done) check("pready_timeout", 32'h0, 32'h1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          w;
    int          max_w;
    int          first_irq;

    initial begin
        preset = 1'b1; psel1 = 1'b0; psel0 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = 8'h0; pwdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 preset = 1'b0;
        #1;
        check("rst_pready", {31'h0, pready1}, 32'h0);
        check("rst_pslverr", {31'h0, pslverr1}, 32'h0);
        check("rst_prdata", prdata1, 32'h0);
        check("rst_count", {16'h0, count1}, 32'h0);
        check("rst_irq", {31'h0, irq1}, 32'h0);
        apb(1, 8'hFC, 0, 32'h0, rd, er, w);
        check("rst_ctrl", rd, 32'h0000_0064);

        // Write/read-back with one wait state
        apb(1, 8'h05, 1, 32'hDEAD_BEEF, rd, er, w);
        check("ws1_wr_waits", w, 1);
        check("ws1_wr_count", {16'h0, count1}, 32'd1);
        apb(1, 8'h05, 0, 32'h0, rd, er, w);
        check("ws1_rd_data", rd, 32'hDEAD_BEEF);
        check("ws1_rd_err", {31'h0, er}, 32'h0);
        apb(1, 8'hF8, 0, 32'h0, rd, er, w);
        check("ws1_rd_count", rd, 32'd1);

        // Zero-wait burst
        max_w = 0;
        first_irq = -1;
        for (int i = 0; i < 128; i++) begin
            apb(0, 8'(i), 1, i, rd, er, w);
            if (w > max_w) max_w = w;
            if (irq0 && first_irq < 0) first_irq = i;
        end
        check("burst_max_waits", max_w, 0);
        check("burst_count", {16'h0, count0}, 32'd128);
        check("burst_irq_at", first_irq, 32'h63);
        apb(0, 8'h2A, 0, 32'h0, rd, er, w);
        check("burst_rd_2a", rd, 32'h2A);

        // Error responses
        apb(1, 8'h80, 1, 32'h1234_5678, rd, er, w);
        check("err_80_err", {31'h0, er}, 32'h1);
        check("err_80_count", {16'h0, count1}, 32'd1);
        apb(1, 8'hF8, 1, 32'h0000_0005, rd, er, w);
        check("err_f8_err", {31'h0, er}, 32'h1);
        check("err_f8_count", {16'h0, count1}, 32'd1);
        apb(1, 8'hF0, 0, 32'h0, rd, er, w);
        check("err_f0_data", rd, 32'h0);
        check("err_f0_err", {31'h0, er}, 32'h1);

        // Clear via CTRL on the zero-wait unit
        check("pre_clr_irq", {31'h0, irq0}, 32'h1);
        apb(0, 8'hFC, 1, 32'h0000_0132, rd, er, w);
        check("clr_count", {16'h0, count0}, 32'd0);
        check("clr_irq", {31'h0, irq0}, 32'h0);
        apb(0, 8'hFC, 0, 32'h0, rd, er, w);
        check("clr_ctrl", rd, 32'h0000_0032);

        // Abort: psel dropped during the wait cycle of a write to 0x05
        @(posedge clk); #1;
        psel1 = 1'b1; penable = 1'b0; paddr = 8'h05; pwrite = 1'b1; pwdata = 32'h1111_1111;
        @(posedge clk); #1;
        penable = 1'b1;
        #1 check("abort_pready", {31'h0, pready1}, 32'h0);
        @(posedge clk); #1;
        psel1 = 1'b0; penable = 1'b0;
        #1 check("abort_pready_drop", {31'h0, pready1}, 32'h0);
        @(posedge clk); #1;
        check("abort_count", {16'h0, count1}, 32'd1);
        apb(1, 8'h05, 0, 32'h0, rd, er, w);
        check("abort_rd_data", rd, 32'hDEAD_BEEF);
        check("abort_rd_waits", w, 1);

        // Reset in the wait cycle of a write to 0x10
        apb(1, 8'h10, 1, 32'hAAAA_5555, rd, er, w);
        @(posedge clk); #1;
        psel1 = 1'b1; penable = 1'b0; paddr = 8'h10; pwrite = 1'b1; pwdata = 32'hBBBB_0000;
        @(posedge clk); #1;
        penable = 1'b1; preset = 1'b1;
        #1 check("rstmid_pready_wait", {31'h0, pready1}, 32'h0);
        @(posedge clk); #1;
        preset = 1'b0;
        #1 check("rstmid_pready_after", {31'h0, pready1}, 32'h0);
        @(posedge clk); #1;
        psel1 = 1'b0; penable = 1'b0;
        check("rstmid_count", {16'h0, count1}, 32'd0);
        @(posedge clk); #1;
        check("rstmid_count_hold", {16'h0, count1}, 32'd0);
        apb(1, 8'h10, 0, 32'h0, rd, er, w);
        check("rstmid_rd_data", rd, 32'hAAAA_5555);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
